// File: rtl/tspi_shift_engine.sv
// rtl/tspi_shift_engine.sv - TSPI serial shift engine: variable-length TX, start-bit wait, variable-length RX
module tspi_shift_engine #(
    parameter int DataWidth    = 32,
    parameter int LenWidth     = $clog2(DataWidth),
    parameter int TimeoutTicks = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tspi_clk_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [LenWidth-1:0]  tx_len_i,
    input  logic [DataWidth-1:0] tx_data_i,
    input  logic                 rx_en_i,
    input  logic [LenWidth-1:0]  rx_len_i,
    input  logic                 lsb_first_i,
    output logic                 mosi_o,
    input  logic                 miso_i,
    output logic                 busy_o,
    output logic                 start_bit_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 rx_valid_o,
    output logic [DataWidth-1:0] rx_data_o
);

    typedef enum logic [1:0] {
        IDLE,
        TX,
        WAIT_START,
        RX
    } state_t;

    localparam int TmoWidth = $clog2(TimeoutTicks + 1);
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutTicks - 1);

    state_t               state;
    logic                 tspi_clk_q;
    logic                 tick;
    logic [LenWidth-1:0]  bit_cnt;
    logic [LenWidth-1:0]  tx_len_q;
    logic [LenWidth-1:0]  rx_len_q;
    logic [DataWidth-1:0] tx_data_q;
    logic [DataWidth-1:0] rx_shift;
    logic [DataWidth-1:0] rx_next;
    logic                 rx_en_q;
    logic                 lsb_q;
    logic [TmoWidth-1:0]  tmo_cnt;
    logic [LenWidth-1:0]  tx_idx;
    logic [LenWidth-1:0]  rx_idx;

    assign tick = tspi_clk_i & ~tspi_clk_q;

    // bit_cnt counts remaining bits down to 0; LSB-first walks the index upward instead
    assign tx_idx = lsb_q ? (tx_len_q - bit_cnt) : bit_cnt;
    assign rx_idx = rx_len_q - bit_cnt;

    assign busy_o      = (state != IDLE);
    assign mosi_o      = (state == TX) ? tx_data_q[tx_idx] : 1'b1;
    assign start_bit_o = (state == WAIT_START) & tick & ~miso_i & ~abort_i;

    always_comb begin
        rx_next = rx_shift;
        if (lsb_q) begin
            rx_next[rx_idx] = miso_i;
        end else begin
            rx_next = {rx_shift[DataWidth-2:0], miso_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            tspi_clk_q <= 1'b0;
            bit_cnt    <= '0;
            tx_len_q   <= '0;
            rx_len_q   <= '0;
            tx_data_q  <= '0;
            rx_shift   <= '0;
            rx_en_q    <= 1'b0;
            lsb_q      <= 1'b0;
            tmo_cnt    <= '0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
        end else begin
            tspi_clk_q <= tspi_clk_i;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            rx_valid_o <= 1'b0;
            if (abort_i) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            tx_len_q  <= tx_len_i;
                            tx_data_q <= tx_data_i;
                            rx_en_q   <= rx_en_i;
                            rx_len_q  <= rx_len_i;
                            lsb_q     <= lsb_first_i;
                            bit_cnt   <= tx_len_i;
                            state     <= TX;
                        end
                    end
                    TX: begin
                        if (tick) begin
                            if (bit_cnt == '0) begin
                                if (rx_en_q) begin
                                    state   <= WAIT_START;
                                    tmo_cnt <= '0;
                                end else begin
                                    state  <= IDLE;
                                    done_o <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - LenWidth'(1);
                            end
                        end
                    end
                    WAIT_START: begin
                        if (tick) begin
                            if (!miso_i) begin
                                state    <= RX;
                                bit_cnt  <= rx_len_q;
                                rx_shift <= '0;
                            end else if (tmo_cnt == TmoLast) begin
                                state     <= IDLE;
                                tmo_cnt   <= '0;
                                done_o    <= 1'b1;
                                timeout_o <= 1'b1;
                            end else begin
                                tmo_cnt <= tmo_cnt + TmoWidth'(1);
                            end
                        end
                    end
                    RX: begin
                        if (tick) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == '0) begin
                                state      <= IDLE;
                                rx_data_o  <= rx_next;
                                rx_valid_o <= 1'b1;
                                done_o     <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - LenWidth'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tspi_shift_engine.sv
// tb/tb_tspi_shift_engine.sv - table-driven bench for tspi_shift_engine
module tb_tspi_shift_engine;

    localparam int DW  = 32;
    localparam int LW  = 5;
    localparam int TMO = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          tspi_clk_i;
    logic          start_i;
    logic          abort_i;
    logic [LW-1:0] tx_len_i;
    logic [DW-1:0] tx_data_i;
    logic          rx_en_i;
    logic [LW-1:0] rx_len_i;
    logic          lsb_first_i;
    logic          mosi_o;
    logic          miso_i;
    logic          busy_o;
    logic          start_bit_o;
    logic          done_o;
    logic          timeout_o;
    logic          rx_valid_o;
    logic [DW-1:0] rx_data_o;

    tspi_shift_engine #(
        .DataWidth   (DW),
        .LenWidth    (LW),
        .TimeoutTicks(TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tspi_clk_i (tspi_clk_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .tx_len_i   (tx_len_i),
        .tx_data_i  (tx_data_i),
        .rx_en_i    (rx_en_i),
        .rx_len_i   (rx_len_i),
        .lsb_first_i(lsb_first_i),
        .mosi_o     (mosi_o),
        .miso_i     (miso_i),
        .busy_o     (busy_o),
        .start_bit_o(start_bit_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o)
    );

    always #5 clk_i = ~clk_i;

    // mosi_seq / rx_bits are written first-on-the-wire at the top (bit len down to bit 0)
    typedef struct {
        logic        lsb;
        logic [4:0]  tx_len;
        logic [31:0] tx_data;
        logic [31:0] mosi_seq;
        logic        rx_en;
        logic [4:0]  rx_len;
        int          wait_ones;
        logic [31:0] rx_bits;
        logic        exp_tmo;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[8];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done, n_tmo, n_rxv, n_sb, done_cyc, rxv_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic sclk, input logic miso, input logic st, input logic ab);
        @(posedge clk_i);
        #1;
        tspi_clk_i = sclk;
        miso_i     = miso;
        start_i    = st;
        abort_i    = ab;
        @(negedge clk_i);
        cyc++;
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (timeout_o) n_tmo++;
        if (rx_valid_o) begin
            n_rxv++;
            rxv_cyc = cyc;
        end
        if (start_bit_o) n_sb++;
    endtask

    task automatic clear_mon();
        n_done   = 0;
        n_tmo    = 0;
        n_rxv    = 0;
        n_sb     = 0;
        done_cyc = -1;
        rxv_cyc  = -1;
    endtask

    task automatic load(input vec_t v);
        lsb_first_i = v.lsb;
        tx_len_i    = v.tx_len;
        tx_data_i   = v.tx_data;
        rx_en_i     = v.rx_en;
        rx_len_i    = v.rx_len;
    endtask

    task automatic run_txn(input int id, input vec_t v);
        int   last_tick;
        int   idx;
        logic m;
        last_tick = 0;
        load(v);
        clear_mon();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk($sformatf("v%0d busy in start cycle", id), busy_o, 1'b0);
        for (int k = 0; k <= int'(v.tx_len); k++) begin
            idx = int'(v.tx_len) - k;
            step(1'b1, 1'b1, 1'b0, 1'b0);
            last_tick = cyc;
            chk($sformatf("v%0d mosi bit %0d", id, k), mosi_o, v.mosi_seq[idx]);
            if (k == 0) chk($sformatf("v%0d busy in tx", id), busy_o, 1'b1);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        if (v.rx_en) begin
            for (int w = 0; w < v.wait_ones; w++) begin
                step(1'b1, 1'b1, 1'b0, 1'b0);
                last_tick = cyc;
                chk($sformatf("v%0d mosi idle in wait %0d", id, w), mosi_o, 1'b1);
                step(1'b1, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0, 1'b0);
            end
            if (!v.exp_tmo) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                chk($sformatf("v%0d start_bit pulse", id), start_bit_o, 1'b1);
                step(1'b1, 1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b1, 1'b0, 1'b0);
                for (int k = 0; k <= int'(v.rx_len); k++) begin
                    idx = int'(v.rx_len) - k;
                    m   = v.rx_bits[idx];
                    step(1'b1, m, 1'b0, 1'b0);
                    last_tick = cyc;
                    step(1'b1, m, 1'b0, 1'b0);
                    step(1'b0, m, 1'b0, 1'b0);
                    step(1'b0, m, 1'b0, 1'b0);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("v%0d done count", id), n_done, 1);
        chk($sformatf("v%0d done latency", id), done_cyc, last_tick + 1);
        chk($sformatf("v%0d timeout count", id), n_tmo, {31'd0, v.exp_tmo});
        chk($sformatf("v%0d rx_valid count", id), n_rxv, {31'd0, v.rx_en & ~v.exp_tmo});
        chk($sformatf("v%0d start_bit count", id), n_sb, {31'd0, v.rx_en & ~v.exp_tmo});
        if (n_rxv == 1) chk($sformatf("v%0d rx_valid with done", id), rxv_cyc, done_cyc);
        chk($sformatf("v%0d rx_data", id), rx_data_o, v.exp_rx);
        chk($sformatf("v%0d busy after", id), busy_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int zeros;
        vec_t v;
        //          lsb   tx_len  tx_data        mosi_seq       rx_en rx_len wait rx_bits        tmo   exp_rx
        vecs[0] = '{1'b0, 5'd7,  32'h000000A5, 32'h000000A5, 1'b0, 5'd0,  0, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b1, 5'd7,  32'h000000C1, 32'h00000083, 1'b0, 5'd0,  0, 32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b1, 5'd1,  32'h00000003, 32'h00000003, 1'b1, 5'd3,  3, 32'h0000000D, 1'b0, 32'h0000000B};
        vecs[3] = '{1'b0, 5'd1,  32'h00000002, 32'h00000002, 1'b1, 5'd7,  4, 32'h0,        1'b1, 32'h0000000B};
        vecs[4] = '{1'b0, 5'd31, 32'h12345678, 32'h12345678, 1'b1, 5'd31, 0, 32'h80000001, 1'b0, 32'h80000001};
        vecs[5] = '{1'b0, 5'd3,  32'h00000009, 32'h00000009, 1'b1, 5'd4,  2, 32'h00000016, 1'b0, 32'h00000016};
        vecs[6] = '{1'b1, 5'd2,  32'h00000005, 32'h00000005, 1'b1, 5'd2,  1, 32'h00000004, 1'b0, 32'h00000001};
        vecs[7] = '{1'b0, 5'd0,  32'hFFFFFFF0, 32'h00000000, 1'b0, 5'd0,  0, 32'h0,        1'b0, 32'h00000001};

        rst_ni     = 1'b0;
        tspi_clk_i = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        miso_i     = 1'b1;
        load(vecs[0]);
        clear_mon();
        repeat (2) @(negedge clk_i);
        chk("reset mosi", mosi_o, 1'b1);
        chk("reset busy", busy_o, 1'b0);
        chk("reset done", done_o, 1'b0);
        chk("reset timeout", timeout_o, 1'b0);
        chk("reset rx_valid", rx_valid_o, 1'b0);
        chk("reset start_bit", start_bit_o, 1'b0);
        chk("reset rx_data", rx_data_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // abort during RX after three samples
        v = vecs[6];
        v.lsb = 1'b0; v.tx_len = 5'd0; v.tx_data = 32'h1; v.rx_len = 5'd7;
        load(v);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        clear_mon();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort busy", busy_o, 1'b0);
        chk("abort mosi", mosi_o, 1'b1);
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("abort pulses", n_done + n_rxv + n_sb + n_tmo, 0);
        chk("abort rx_data kept", rx_data_o, 32'h1);
        run_txn(100, vecs[5]);

        // start together with abort is dropped
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start+abort dropped", busy_o, 1'b0);

        // back-to-back: start in the done cycle
        v = vecs[7];
        v.tx_data = 32'h1;
        load(v);
        clear_mon();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("b2b first mosi", mosi_o, 1'b1);
        tx_data_i = 32'h0;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2b done with start", done_o, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b busy again", busy_o, 1'b1);
        chk("b2b second mosi", mosi_o, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b done count", n_done, 2);

        // tspi_clk held high for 20 cycles advances exactly one bit
        v = vecs[3];
        v.rx_en = 1'b0;
        load(v);
        clear_mon();
        zeros = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 20; s++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (mosi_o == 1'b0) zeros++;
        end
        chk("held high shifts", zeros, 19);
        chk("held high no done", n_done, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("held high final done", n_done, 1);

        // asynchronous reset in the middle of RX
        load(vecs[5]);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async reset busy", busy_o, 1'b0);
        chk("async reset mosi", mosi_o, 1'b1);
        chk("async reset rx_data", rx_data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tspi_shift_engine.md
Name: tspi_shift_engine

Overview:
Parametrised successor of the TSPI shift register. It serialises a variable-length command on mosi_o, then optionally waits for a target start bit on miso_i and deserialises a variable-length response. Both lengths, bit order and response capture are per-transaction. It runs entirely in the clk_i domain and advances only on detected rising edges of tspi_clk_i. It sits between the TSPI controller FSM and the pads.

Parameters:
DataWidth, 32, maximum bits per TX or RX phase (>=2)
LenWidth, $clog2(DataWidth), width of the length fields
TimeoutTicks, 256, tspi_clk rising edges allowed in WAIT_START before abandoning

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
tspi_clk_i  in  1  serial clock, already synchronous to clk_i
start_i  in  1  single-cycle transaction request
abort_i  in  1  synchronous abort, returns to IDLE
tx_len_i  in  LenWidth  TX bit count minus 1
tx_data_i  in  DataWidth  TX payload, right-aligned
rx_en_i  in  1  1 = response phase follows TX
rx_len_i  in  LenWidth  RX bit count minus 1
lsb_first_i  in  1  0 = MSB-first, 1 = LSB-first (applies to TX and RX)
mosi_o  out  1  serial data out
miso_i  in  1  serial data in
busy_o  out  1  state != IDLE
start_bit_o  out  1  one-cycle pulse when the start bit is detected
done_o  out  1  one-cycle pulse when a transaction ends (normal or timeout)
timeout_o  out  1  one-cycle pulse, qualifies done_o
rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
rx_data_o  out  DataWidth  last received word, right-aligned, zero-extended

Behaviour:
- Reset: state IDLE; mosi_o=1; busy_o, start_bit_o, done_o, timeout_o, rx_valid_o = 0; rx_data_o = 0; edge register = 0; all counters = 0.
- tick = tspi_clk_i & ~tspi_clk_q. tspi_clk_q is a flop with reset value 0. All shifting, sampling and timeout counting happen only in tick cycles.
- start_i, tx_len_i, tx_data_i, rx_en_i, rx_len_i and lsb_first_i are latched only on start_i in IDLE. start_i is ignored outside IDLE.
- IDLE: mosi_o=1. On start_i, go to TX with bit_cnt=tx_len_i.
- TX: mosi_o is combinationally the current bit. The first bit is valid in the cycle after start_i. MSB-first sends tx_data_i[tx_len] down to [0]; LSB-first sends [0] up to [tx_len]. Each tick advances one bit. On the tick of the last bit, go to WAIT_START if rx_en is set; otherwise go to IDLE with done_o pulsed in the next cycle.
- WAIT_START: mosi_o=1 and tmo_cnt=0 on entry.
  - On a tick with miso_i=0: start_bit_o pulses in that same cycle (combinational); go to RX with bit_cnt=rx_len.
  - On a tick with miso_i=1: tmo_cnt increments. When it reaches TimeoutTicks, go to IDLE; done_o and timeout_o pulse together in the next cycle; rx_valid_o stays 0 and rx_data_o is unchanged.
- RX: mosi_o=1. Each tick samples miso_i; the start-bit tick does not sample. MSB-first shifts bits into the LSB. LSB-first places bit k at index k. After rx_len+1 samples, go to IDLE. In the next cycle rx_data_o is updated (bits above rx_len = 0), and rx_valid_o and done_o pulse.
- Total latency for a TX-only transaction: tx_len+1 ticks after start_i, plus 1 cycle to done_o.
- abort_i has priority over all other events. It goes to IDLE in the next cycle with mosi_o=1 and clears counters. No done_o, rx_valid_o, start_bit_o or timeout_o is produced by the abort. rx_data_o is retained.
- start_i in the same cycle as a done_o pulse is accepted, because the state is already IDLE. start_i together with abort_i is dropped.
- tspi_clk_i held high never produces a second tick. Any number of clk_i cycles between ticks is legal.
- Length 0 means 1 bit. tx_len = DataWidth-1 sends the full word. No wrap beyond DataWidth is possible.
- Asynchronous reset mid-transaction returns immediately to the reset values.

Test Plan:
- MSB-first TX only: tx_data=0x000000A5, tx_len=7, rx_en=0, tspi_clk period 4 clk. Required: mosi sequence 1,0,1,0,0,1,0,1; done_o pulses once, 1 cycle after the 8th tick; busy_o then falls.
- LSB-first TX + RX: tx=0x3, tx_len=1; miso stays 1 for 3 ticks, then 0, then 1,1,0,1. Required with rx_len=3: start_bit_o pulses on the 4th WAIT tick; rx_data_o=0x0000000B; rx_valid_o and done_o pulse together.
- Timeout: TimeoutTicks=4 and miso held 1 after TX. Required: done_o and timeout_o pulse 1 cycle after the 4th WAIT tick; rx_valid_o=0; rx_data_o unchanged.
- Full width MSB-first RX: tx_len=31, rx_len=31, miso returns 0x80000001 after the start bit. Required: rx_data_o=0x80000001.
- Abort in RX after 3 samples. Required: next cycle IDLE, mosi_o=1, no pulses; a new start_i works normally.
- Back-to-back: start_i asserted in the done_o cycle is accepted, with its first mosi bit valid in the following cycle. tspi_clk_i held high for 20 cycles produces exactly one shift.
